// File: rtl/reflet_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reflet_mem_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a shared memory
//            alignment fixer. The granted request is latched, presented on
//            the shared bus until the fixer answers, and then completed with
//            a one-cycle ready pulse or a one-cycle alignment-error pulse
//            back to the requester that owned it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset              : clock, synchronous active-high reset
//   pX_addr / pX_data_out   : requester X byte address and write data
//   pX_size                 : requester X size code, bytes = 2^size
//   pX_read_en/pX_write_en  : requester X request, held until ready/error
//   pX_data_in              : registered read data returned to requester X
//   pX_ready / pX_error     : one-cycle completion / alignment-error pulses
//   mem_addr/mem_data_out/
//   mem_size                : latched transaction presented to the fixer
//   mem_read_en/mem_write_en: shared bus strobes
//   mem_data_in             : read data from the fixer
//   mem_ready               : fixer completes the access on this cycle
//   mem_alignment_error     : fixer rejects the presented address/size
// ============================================================================
module reflet_mem_arbiter #(
    parameter int word_size = 32,
    parameter int addr_size = 32
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [addr_size-1:0]          p0_addr,
    input  logic [word_size-1:0]          p0_data_out,
    input  logic [$clog2(word_size/8):0]  p0_size,
    input  logic                          p0_read_en,
    input  logic                          p0_write_en,
    output logic [word_size-1:0]          p0_data_in,
    output logic                          p0_ready,
    output logic                          p0_error,

    input  logic [addr_size-1:0]          p1_addr,
    input  logic [word_size-1:0]          p1_data_out,
    input  logic [$clog2(word_size/8):0]  p1_size,
    input  logic                          p1_read_en,
    input  logic                          p1_write_en,
    output logic [word_size-1:0]          p1_data_in,
    output logic                          p1_ready,
    output logic                          p1_error,

    output logic [addr_size-1:0]          mem_addr,
    output logic [word_size-1:0]          mem_data_out,
    output logic [$clog2(word_size/8):0]  mem_size,
    output logic                          mem_read_en,
    output logic                          mem_write_en,
    input  logic [word_size-1:0]          mem_data_in,
    input  logic                          mem_ready,
    input  logic                          mem_alignment_error
);

    localparam int SIZE_W = $clog2(word_size/8) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Request decode
    logic w_req0;
    logic w_req1;

    // Control strobes produced by the next-state logic
    logic w_start;      // grant issued this cycle, latch the winner
    logic w_sel;        // winning port (0/1) when w_start is set
    logic w_capture;    // read completing, capture mem_data_in
    logic w_fail;       // fixer reported an alignment error

    // Latched transaction
    logic                 r_grant;
    logic                 r_last_grant;
    logic                 r_write;
    logic [addr_size-1:0] r_addr;
    logic [word_size-1:0] r_wdata;
    logic [SIZE_W-1:0]    r_size;

    // Per-port returned data and error pulses
    logic [word_size-1:0] r_rdata0;
    logic [word_size-1:0] r_rdata1;
    logic                 r_err0;
    logic                 r_err1;

    assign w_req0 = p0_read_en | p0_write_en;
    assign w_req1 = p1_read_en | p1_write_en;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_sel        = 1'b0;
        w_capture    = 1'b0;
        w_fail       = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        p0_ready     = 1'b0;
        p1_ready     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The cycle carrying an error pulse is the requester's
                // last cycle of holding that same request; granting here
                // would replay the rejected access, so wait one cycle.
                if (!(r_err0 | r_err1) && (w_req0 | w_req1)) begin
                    w_start      = 1'b1;
                    // On a tie the port not served last time wins.
                    w_sel        = (w_req0 & w_req1) ? ~r_last_grant : w_req1;
                    w_next_state = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                mem_read_en  = ~r_write;
                mem_write_en =  r_write;
                // An error takes precedence over a simultaneous ready.
                if (mem_alignment_error) begin
                    w_fail       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (mem_ready) begin
                    w_capture    = ~r_write;
                    w_next_state = ST_DONE;
                end
            end

            ST_DONE: begin
                p0_ready     = ~r_grant;
                p1_ready     =  r_grant;
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction latch, round-robin memory, returned data and error pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= 1'b0;
            // Pretend port 1 was served last so port 0 wins the first tie.
            r_last_grant <= 1'b1;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_err0 <= w_fail & ~r_grant;
            r_err1 <= w_fail &  r_grant;

            if (w_start) begin
                r_grant <= w_sel;
                if (w_sel) begin
                    r_addr  <= p1_addr;
                    r_wdata <= p1_data_out;
                    r_size  <= p1_size;
                    r_write <= p1_write_en;
                end else begin
                    r_addr  <= p0_addr;
                    r_wdata <= p0_data_out;
                    r_size  <= p0_size;
                    r_write <= p0_write_en;
                end
            end

            if (w_capture) begin
                if (r_grant) begin
                    r_rdata1 <= mem_data_in;
                end else begin
                    r_rdata0 <= mem_data_in;
                end
            end

            // Only successful completions advance the rotation.
            if (r_state == ST_DONE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign mem_addr     = r_addr;
    assign mem_data_out = r_wdata;
    assign mem_size     = r_size;
    assign p0_data_in   = r_rdata0;
    assign p1_data_in   = r_rdata1;
    assign p0_error     = r_err0;
    assign p1_error     = r_err1;

endmodule
`default_nettype wire

// File: tb/tb_reflet_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reflet_mem_arbiter
// Purpose  : Self-checking bench for reflet_mem_arbiter. Each task drives one
//            scenario; expected completions are queued when a request is
//            driven and popped when the arbiter pulses ready or error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reflet_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p0_addr, p1_addr, p0_data_out, p1_data_out;
    logic [31:0] p0_data_in, p1_data_in;
    logic [2:0]  p0_size, p1_size, mem_size;
    logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
    logic        p0_ready, p1_ready, p0_error, p1_error;
    logic [31:0] mem_addr, mem_data_out, mem_data_in;
    logic        mem_read_en, mem_write_en, mem_ready, mem_alignment_error;

    reflet_mem_arbiter #(.word_size(32), .addr_size(32)) dut (
        .clk(clk), .reset(reset),
        .p0_addr(p0_addr), .p0_data_out(p0_data_out), .p0_size(p0_size),
        .p0_read_en(p0_read_en), .p0_write_en(p0_write_en),
        .p0_data_in(p0_data_in), .p0_ready(p0_ready), .p0_error(p0_error),
        .p1_addr(p1_addr), .p1_data_out(p1_data_out), .p1_size(p1_size),
        .p1_read_en(p1_read_en), .p1_write_en(p1_write_en),
        .p1_data_in(p1_data_in), .p1_ready(p1_ready), .p1_error(p1_error),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_size(mem_size),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready),
        .mem_alignment_error(mem_alignment_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] data;   // expected pX_data_in after completion
    } exp_t;

    exp_t sb[$];

    // Advance one cycle; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_addr = '0; p1_addr = '0; p0_data_out = '0; p1_data_out = '0;
        p0_size = '0; p1_size = '0;
        p0_read_en = 1'b0; p0_write_en = 1'b0;
        p1_read_en = 1'b0; p1_write_en = 1'b0;
        mem_data_in = '0; mem_ready = 1'b0; mem_alignment_error = 1'b0;
    endtask

    task automatic sb_pop(output exp_t e, output bit ok);
        ok = (sb.size() > 0);
        e.port = 1'b0; e.err = 1'b0; e.data = '0;
        if (ok) e = sb.pop_front();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_read_en, mem_write_en}); end
        checks++; if ({p0_ready, p1_ready, p0_error, p1_error} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {p0_ready, p1_ready, p0_error, p1_error}); end
        checks++; if (p0_data_in !== 32'h0) begin errors++; $display("FAIL reset_p0_data_in: got %h expected 0", p0_data_in); end
        checks++; if (p1_data_in !== 32'h0) begin errors++; $display("FAIL reset_p1_data_in: got %h expected 0", p1_data_in); end
        checks++; if ({mem_addr, mem_data_out, mem_size} !== 67'h0) begin errors++; $display("FAIL reset_mem_bus: got %h %h %h expected 0", mem_addr, mem_data_out, mem_size); end
        reset = 1'b0;
        tick(); tick();
        checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin errors++; $display("FAIL idle_no_request: got %b expected 00", {mem_read_en, mem_write_en}); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_read();
        exp_t e; bit ok;
        mem_ready = 1'b1; mem_data_in = 32'hDEADBEEF;
        p0_addr = 32'h10; p0_size = 3'd2; p0_read_en = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hDEADBEEF});
        tick();  // cycle 1
        checks++; if ({mem_read_en, mem_write_en} !== 2'b10) begin errors++; $display("FAIL read_strobe_c1: got %b expected 10", {mem_read_en, mem_write_en}); end
        checks++; if ({mem_addr, mem_size} !== {32'h10, 3'd2}) begin errors++; $display("FAIL read_bus_c1: got %h/%0d expected 10/2", mem_addr, mem_size); end
        checks++; if (p0_ready !== 1'b0) begin errors++; $display("FAIL read_early_ready: got %b expected 0", p0_ready); end
        tick();  // cycle 2
        checks++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL read_ready_c2: got %b expected 1", p0_ready); end
        if (p0_ready || p1_ready) begin
            sb_pop(e, ok);
            checks++; if (!ok || e.port !== 1'b0 || e.err !== 1'b0) begin errors++; $display("FAIL read_sb_port: got p1_ready=%b expected port %0d", p1_ready, e.port); end
            checks++; if (p0_data_in !== e.data) begin errors++; $display("FAIL read_data: got %h expected %h", p0_data_in, e.data); end
        end
        p0_read_en = 1'b0;
        tick();
        checks++; if ({p0_ready, mem_read_en} !== 2'b00) begin errors++; $display("FAIL read_pulse_width: got %b expected 00", {p0_ready, mem_read_en}); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_round_robin();
        exp_t e; bit ok;
        int n0 = 0, n1 = 0;
        reset = 1'b1; idle_inputs(); tick(); reset = 1'b0;
        mem_ready = 1'b1; mem_data_in = 32'h0BADF00D;
        p0_addr = 32'h100; p0_data_out = 32'hA0; p0_size = 3'd2; p0_write_en = 1'b1;
        p1_addr = 32'h200; p1_data_out = 32'hB0; p1_size = 3'd2; p1_write_en = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{port: k[0], err: 1'b0, data: 32'h0});
        for (int c = 0; c < 40 && (n0 + n1) < 4; c++) begin
            tick();
            if ((mem_read_en || mem_write_en) && sb.size() > 0) begin
                checks++;
                if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 ||
                    mem_data_out !== (sb[0].port ? p1_data_out : p0_data_out) ||
                    mem_addr !== (sb[0].port ? p1_addr : p0_addr)) begin
                    errors++; $display("FAIL rr_bus: got addr %h data %h expected port %0d", mem_addr, mem_data_out, sb[0].port);
                end
            end
            if (p0_ready || p1_ready || p0_error || p1_error) begin
                sb_pop(e, ok);
                checks++; if (!ok || {p1_ready, p0_ready} !== (e.port ? 2'b10 : 2'b01) || (p0_error | p1_error)) begin errors++; $display("FAIL rr_order: got ready %b%b expected port %0d", p1_ready, p0_ready, e.port); end
                if (p0_ready) begin n0++; p0_data_out++; if (n0 == 2) p0_write_en = 1'b0; end
                if (p1_ready) begin n1++; p1_data_out++; if (n1 == 2) p1_write_en = 1'b0; end
            end
        end
        checks++; if (n0 !== 2 || n1 !== 2) begin errors++; $display("FAIL rr_counts: got %0d/%0d expected 2/2", n0, n1); end
        checks++; if ({p0_data_in, p1_data_in} !== 64'h0) begin errors++; $display("FAIL rr_write_no_capture: got %h/%h expected 0/0", p0_data_in, p1_data_in); end
        p0_write_en = 1'b0; p1_write_en = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_wait_states();
        exp_t e; bit ok;
        int wcnt = 0, r0 = 0, r1 = 0;
        mem_ready = 1'b0; mem_data_in = 32'h55AA55AA;
        p1_addr = 32'h6; p1_data_out = 32'h1234; p1_size = 3'd1; p1_write_en = 1'b1;
        sb.push_back('{port: 1'b1, err: 1'b0, data: 32'h0});
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_write_en) begin
                wcnt++;
                checks++; if ({mem_addr, mem_data_out, mem_size} !== {32'h6, 32'h1234, 3'd1}) begin errors++; $display("FAIL wait_bus_stable: got %h/%h/%0d expected 6/1234/1", mem_addr, mem_data_out, mem_size); end
                mem_ready = (wcnt >= 4);
            end
            if (p0_ready) r0++;
            if (p1_ready || p1_error) begin
                sb_pop(e, ok);
                checks++; if (!ok || e.port !== 1'b1 || p1_error !== 1'b0) begin errors++; $display("FAIL wait_sb: got err %b expected port1 ready", p1_error); end
                r1++;
                p1_write_en = 1'b0;
            end
        end
        checks++; if (wcnt !== 4) begin errors++; $display("FAIL wait_strobe_cycles: got %0d expected 4", wcnt); end
        checks++; if (r1 !== 1 || r0 !== 0) begin errors++; $display("FAIL wait_ready_count: got p1 %0d p0 %0d expected 1 0", r1, r0); end
        checks++; if (p1_data_in !== 32'h0) begin errors++; $display("FAIL wait_write_no_capture: got %h expected 0", p1_data_in); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_align_error();
        exp_t e; bit ok;
        int e0 = 0, r0 = 0, err_cyc = -1;
        mem_ready = 1'b1; mem_alignment_error = 1'b1; mem_data_in = 32'h13579BDF;
        p0_addr = 32'h2; p0_size = 3'd2; p0_data_out = 32'h77; p0_write_en = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b1, data: 32'h0});
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                checks++; if (mem_write_en !== 1'b1) begin errors++; $display("FAIL align_strobe_c1: got %b expected 1", mem_write_en); end
            end
            if (p0_ready || p1_ready) r0++;
            if (p0_error || p1_error) begin
                sb_pop(e, ok);
                checks++; if (!ok || e.err !== 1'b1 || {p1_error, p0_error} !== 2'b01) begin errors++; $display("FAIL align_sb: got err %b%b expected 01", p1_error, p0_error); end
                checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin errors++; $display("FAIL align_strobes_dropped: got %b expected 00", {mem_read_en, mem_write_en}); end
                e0++; err_cyc = c;
                p0_write_en = 1'b0;
            end
        end
        checks++; if (e0 !== 1 || err_cyc !== 2) begin errors++; $display("FAIL align_error_pulse: got %0d pulses at cycle %0d expected 1 at 2", e0, err_cyc); end
        checks++; if (r0 !== 0) begin errors++; $display("FAIL align_no_ready: got %0d expected 0", r0); end
        checks++; if ({mem_read_en, mem_write_en, p0_data_in} !== 34'h0) begin errors++; $display("FAIL align_idle: got %b %h expected idle", {mem_read_en, mem_write_en}, p0_data_in); end
        mem_alignment_error = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_access();
        exp_t e; bit ok;
        int got = 0, stray = 0;
        // Complete a port-0 write first so the rotation points at port 1.
        mem_ready = 1'b1;
        p0_addr = 32'h40; p0_size = 3'd2; p0_data_out = 32'h5; p0_write_en = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, data: 32'h0});
        for (int c = 0; c < 10 && got == 0; c++) begin
            tick();
            if (p0_ready || p1_ready || p0_error || p1_error) begin
                sb_pop(e, ok);
                checks++; if (!ok || p0_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_write: got %b expected 1", p0_ready); end
                got = 1; p0_write_en = 1'b0;
            end
        end
        tick();
        mem_ready = 1'b0; mem_data_in = 32'h99;
        p1_addr = 32'h50; p1_size = 3'd2; p1_read_en = 1'b1;
        tick();
        checks++; if ({mem_read_en, mem_addr} !== {1'b1, 32'h50}) begin errors++; $display("FAIL rst_access: got %b/%h expected 1/50", mem_read_en, mem_addr); end
        reset = 1'b1; mem_ready = 1'b1;
        tick();
        checks++; if ({mem_read_en, mem_write_en, p0_ready, p1_ready, p0_error, p1_error} !== 6'b0) begin errors++; $display("FAIL rst_abandon: got %b expected 000000", {mem_read_en, mem_write_en, p0_ready, p1_ready, p0_error, p1_error}); end
        reset = 1'b0; p1_read_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (p0_ready || p1_ready || p0_error || p1_error) stray++;
        end
        checks++; if (stray !== 0 || p1_data_in !== 32'h0) begin errors++; $display("FAIL rst_no_pulse: got %0d pulses data %h expected 0 0", stray, p1_data_in); end
        // Tie after reset: port 0 must be served first.
        mem_data_in = 32'h11112222;
        p0_addr = 32'h60; p0_read_en = 1'b1;
        p1_addr = 32'h70; p1_read_en = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, data: 32'h11112222});
        sb.push_back('{port: 1'b1, err: 1'b0, data: 32'h11112222});
        tick();
        checks++; if ({mem_read_en, mem_addr} !== {1'b1, 32'h60}) begin errors++; $display("FAIL rst_tie_grant: got %b/%h expected 1/60", mem_read_en, mem_addr); end
        got = 0;
        for (int c = 0; c < 15 && got < 2; c++) begin
            tick();
            if (p0_ready || p1_ready || p0_error || p1_error) begin
                sb_pop(e, ok);
                checks++;
                if (!ok || {p1_ready, p0_ready} !== (e.port ? 2'b10 : 2'b01) ||
                    (e.port ? p1_data_in : p0_data_in) !== e.data) begin
                    errors++; $display("FAIL rst_tie_sb: got ready %b%b data %h/%h expected port %0d data %h", p1_ready, p0_ready, p0_data_in, p1_data_in, e.port, e.data);
                end
                if (p0_ready) p0_read_en = 1'b0;
                if (p1_ready) p1_read_en = 1'b0;
                got++;
            end
        end
        checks++; if (got !== 2) begin errors++; $display("FAIL rst_tie_done: got %0d completions expected 2", got); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_addr_change();
        exp_t e; bit ok;
        int acnt = 1, got = 0;
        mem_ready = 1'b0; mem_data_in = 32'hCAFEF00D;
        p0_addr = 32'h20; p0_size = 3'd2; p0_read_en = 1'b1;
        sb.push_back('{port: 1'b0, err: 1'b0, data: 32'hCAFEF00D});
        tick();
        checks++; if ({mem_read_en, mem_addr} !== {1'b1, 32'h20}) begin errors++; $display("FAIL chg_first_access: got %b/%h expected 1/20", mem_read_en, mem_addr); end
        p0_addr = 32'h30; p0_size = 3'd0; p0_data_out = 32'hFFFF; p0_write_en = 1'b1;
        for (int c = 0; c < 10 && got == 0; c++) begin
            tick();
            if (mem_read_en || mem_write_en) begin
                acnt++;
                checks++; if ({mem_read_en, mem_write_en, mem_addr, mem_size} !== {2'b10, 32'h20, 3'd2}) begin errors++; $display("FAIL chg_latched: got %b%b %h %0d expected 10 20 2", mem_read_en, mem_write_en, mem_addr, mem_size); end
                mem_ready = (acnt >= 2);
            end
            if (p0_ready || p1_ready || p0_error || p1_error) begin
                sb_pop(e, ok);
                checks++; if (!ok || p0_ready !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL chg_done: got ready %b addr %h expected 1 20", p0_ready, mem_addr); end
                checks++; if (p0_data_in !== e.data) begin errors++; $display("FAIL chg_data: got %h expected %h", p0_data_in, e.data); end
                p0_read_en = 1'b0; p0_write_en = 1'b0;
                got = 1;
            end
        end
        checks++; if (got !== 1) begin errors++; $display("FAIL chg_timeout: got %0d completions expected 1", got); end
        tick();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_wait_states();
        test_align_error();
        test_reset_mid_access();
        test_addr_change();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drained: got %0d left expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
